peridot_byte2packet: RTL and testbench
======================================

Name: peridot_byte2packet

Overview:
- Converts the de-escaped byte stream leaving the configuration layer (b2p_* side) into an Avalon-ST packet stream with SOP/EOP/channel sidebands for the host-bridge packet-to-transaction stage.
- Decodes the standard control bytes: 0x7A SOP, 0x7B EOP, 0x7C channel, 0x7D escape.
- Sits directly downstream of the configuration layer, in the host bridge clock domain.

Parameters:
- CHANNEL_WIDTH, 8: width of out_channel, 1..8. Only the low CHANNEL_WIDTH bits of the channel byte are kept.
- DROP_OUTSIDE_PACKET, "ENABLE": data bytes received outside a packet are discarded. With "DISABLE" they are forwarded with SOP=EOP=0.

Ports:
- clk, in, 1: host bridge clock, up to 100MHz.
- reset_n, in, 1: asynchronous active-low reset.
- in_ready, out, 1: sink ready, fed from the configuration layer b2p_* interface.
- in_valid, in, 1: sink valid.
- in_data, in, 8: sink byte.
- out_ready, in, 1: source ready.
- out_valid, out, 1: source valid.
- out_data, out, 8: decoded data byte.
- out_startofpacket, out, 1: first byte of packet.
- out_endofpacket, out, 1: last byte of packet.
- out_channel, out, CHANNEL_WIDTH: current channel.
- framing_error, out, 1: one-cycle pulse on a protocol violation.

Behaviour:
- Reset values (asynchronous): out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0, framing_error=0, state=IDLE, esc=0, sop_pend=0, eop_pend=0.
- Handshake:
  - in_ready = !out_valid || out_ready. The output stage is a single registered stage.
  - An input byte is accepted when in_valid && in_ready.
  - out_* hold stable while out_valid && !out_ready.
- Latency: an accepted data byte appears on out_* the next cycle. Control bytes produce no output.
- Escape:
  - Accepting 0x7D with esc=0 sets esc=1.
  - The next accepted byte, whatever its value, is taken as literal (byte ^ 0x20) and clears esc.
- Control bytes are recognised only when esc=0:
  - 0x7A: sop_pend=1, eop_pend=0, state=DATA. If state was already DATA with no EOP seen, pulse framing_error; the previous packet is abandoned with no EOP emitted.
  - 0x7B: eop_pend=1. The next data byte is emitted with out_endofpacket=1, then state=IDLE.
  - 0x7C: state=CHAN. The next byte (escape honoured) loads the channel register, then the block returns to the previous state (IDLE or DATA). 0x7C inside CHAN is taken as the channel value 0x7C only if escaped; unescaped, pulse framing_error and stay in CHAN.
- Data byte (non-control or escaped):
  - In DATA: emit the byte with out_startofpacket=sop_pend and out_endofpacket=eop_pend, then clear both. Single-byte packets (SOP and EOP on the same byte) are legal.
  - In IDLE: discard and pulse framing_error if DROP_OUTSIDE_PACKET="ENABLE", otherwise forward with SOP=EOP=0.
- out_channel updates only when a data byte is emitted. It samples the channel register at that moment; a mid-packet channel change applies to the next emitted byte.
- 0x7B while eop_pend=1: ignored and framing_error pulses.
- 0x7D while esc=1: data byte 0x5D.
- Back-pressure: no byte is lost or duplicated. Control bytes are consumed only when in_ready=1, so decode state never advances during a stall.
- Reset asserted mid-packet: all state clears immediately; a partial packet is never completed.

Decomposition:
- Shared package peridot_hostbridge_pkg holds:
  - localparams SOP_CODE=8'h7A, EOP_CODE=8'h7B, CHANNEL_CODE=8'h7C, ESC_CODE=8'h7D, ESC_XOR=8'h20;
  - the state encoding IDLE/DATA/CHAN.
- The packet-to-byte encoder reuses the same package.
- No sub-module: decoder and output register together fit in one module of about 200 lines.

Test Plan:
- Stream 7A 11 22 7B 33 with out_ready=1 → three beats: 11 (SOP), 22, 33 (EOP). Zero framing_error. Output one cycle after each data accept.
- Stream 7A 7D 5A 7B 7D 5D → beats 7A (SOP), then 7D (EOP).
- Stream 7C 7D 5C 7A 01 7B 02 with CHANNEL_WIDTH=8 → out_channel=0x7C on both beats.
- Stream 7A AA BB 7B CC while out_ready toggles 1,0,0,1 every cycle → in_ready mirrors the stall. Exact sequence AA/BB/CC is preserved; out_* are stable during the stall.
- Send 55 before any SOP with DROP_OUTSIDE_PACKET=ENABLE → no beat and one framing_error pulse. Then 7A 7A 01 7B 02 → one framing_error pulse, then beats 01 (SOP), 02 (EOP).
- Deassert reset_n after 7A 10 (before EOP), release, send 20 → 20 is dropped as outside-packet. All outputs are 0 during reset.

Source files
------------

// File: rtl/peridot_hostbridge_pkg.sv
// Shared host-bridge definitions: byte-stream control codes and
// the byte<->packet framing state encoding.
package peridot_hostbridge_pkg;

  localparam logic [7:0] SOP_CODE     = 8'h7A;
  localparam logic [7:0] EOP_CODE     = 8'h7B;
  localparam logic [7:0] CHANNEL_CODE = 8'h7C;
  localparam logic [7:0] ESC_CODE     = 8'h7D;
  localparam logic [7:0] ESC_XOR      = 8'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CHAN = 2'd2
  } b2p_state_e;

  function automatic logic is_code(input logic [7:0] b);
    return (b == SOP_CODE) || (b == EOP_CODE) ||
           (b == CHANNEL_CODE) || (b == ESC_CODE);
  endfunction

endpackage

// File: rtl/peridot_byte2packet.sv
// Byte stream -> Avalon-ST packet decoder with SOP/EOP/channel.
// Ports: in_* byte sink, out_* packet source, framing_error pulse.
module peridot_byte2packet
  import peridot_hostbridge_pkg::*;
#(
  parameter int    CHANNEL_WIDTH       = 8,
  parameter string DROP_OUTSIDE_PACKET = "ENABLE"
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CHANNEL_WIDTH-1:0] out_channel,
  output logic                     framing_error
);

  localparam bit DROP = (DROP_OUTSIDE_PACKET == "ENABLE");

  b2p_state_e               state;
  b2p_state_e               prev_state;
  logic                     esc;
  logic                     sop_pend;
  logic                     eop_pend;
  logic [CHANNEL_WIDTH-1:0] chan_reg;

  logic       accept;
  logic       raw;
  logic       in_chan;
  logic       in_pkt;
  logic [7:0] lit;
  logic       hit_esc;
  logic       chan_err;
  logic       chan_load;
  logic       hit_sop;
  logic       sop_err;
  logic       eop_any;
  logic       hit_eop;
  logic       eop_err;
  logic       hit_chan;
  logic       is_data;
  logic       emit;
  logic       data_drop;
  logic       fe_next;

  assign in_ready = !out_valid || out_ready;

  // Decode flags are mutually exclusive; "raw" means the byte
  // may be a control code (i.e. it is not escaped).
  always_comb begin
    accept    = in_valid && in_ready;
    raw       = accept && !esc;
    in_chan   = (state == CHAN);
    in_pkt    = (state == DATA);
    lit       = esc ? (in_data ^ ESC_XOR) : in_data;
    hit_esc   = raw && (in_data == ESC_CODE);
    chan_err  = raw && in_chan && (in_data == CHANNEL_CODE);
    chan_load = accept && in_chan && !hit_esc && !chan_err;
    hit_sop   = raw && !in_chan && (in_data == SOP_CODE);
    sop_err   = hit_sop && in_pkt && !eop_pend;
    eop_any   = raw && !in_chan && (in_data == EOP_CODE);
    hit_eop   = eop_any && !eop_pend;
    eop_err   = eop_any && eop_pend;
    hit_chan  = raw && !in_chan && (in_data == CHANNEL_CODE);
    is_data   = accept && !in_chan && !(raw && is_code(in_data));
    emit      = is_data && (in_pkt || !DROP);
    data_drop = is_data && !in_pkt && DROP;
    fe_next   = chan_err || sop_err || eop_err || data_drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_channel       <= '0;
      framing_error     <= 1'b0;
      state             <= IDLE;
      prev_state        <= IDLE;
      esc               <= 1'b0;
      sop_pend          <= 1'b0;
      eop_pend          <= 1'b0;
      chan_reg          <= '0;
    end else begin
      framing_error <= fe_next;
      if (accept) esc <= hit_esc;
      if (out_ready) out_valid <= 1'b0;
      unique case (1'b1)
        hit_sop: begin
          sop_pend <= 1'b1;
          eop_pend <= 1'b0;
          state    <= DATA;
        end
        hit_eop: eop_pend <= 1'b1;
        hit_chan: begin
          prev_state <= state;
          state      <= CHAN;
        end
        chan_load: begin
          chan_reg <= lit[CHANNEL_WIDTH-1:0];
          state    <= prev_state;
        end
        emit: begin
          out_valid         <= 1'b1;
          out_data          <= lit;
          out_startofpacket <= in_pkt && sop_pend;
          out_endofpacket   <= in_pkt && eop_pend;
          out_channel       <= chan_reg;
          if (in_pkt) begin
            sop_pend <= 1'b0;
            eop_pend <= 1'b0;
            if (eop_pend) state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_peridot_byte2packet.sv
// Scoreboard bench for peridot_byte2packet.
// Directed byte streams; monitor pops expected beats.
module tb_peridot_byte2packet;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
    logic [7:0] c;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_ready;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_startofpacket;
  logic       out_endofpacket;
  logic [7:0] out_channel;
  logic       framing_error;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    fe_cnt = 0;
  int    fe_base = 0;
  bit    tog = 1'b0;
  int    pidx = 0;
  bit    pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  logic       hold_prev = 1'b0;
  logic [7:0] prev_d;
  logic       prev_s;
  logic       prev_e;
  logic [7:0] prev_c;

  peridot_byte2packet #(
    .CHANNEL_WIDTH(8),
    .DROP_OUTSIDE_PACKET("ENABLE")
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_ready(in_ready),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket),
    .out_channel(out_channel),
    .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic exp_beat(input logic [7:0] d, input logic s,
                          input logic e, input logic [7:0] c);
    beat_t b;
    b.d = d; b.s = s; b.e = e; b.c = c;
    exp_q.push_back(b);
  endtask

  task automatic drive_rdy();
    if (tog) begin
      out_ready = pat[pidx % 4];
      pidx++;
    end else begin
      out_ready = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    drive_rdy();
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      drive_rdy();
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout act=stalled exp=accept byte=%0h", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic flush();
    int n;
    n = 0;
    @(negedge clk);
    tog = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("beats_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_fe(input string nm, input int exp);
    chk(nm, fe_cnt - fe_base, exp);
    fe_base = fe_cnt;
  endtask

  // Monitor: samples 2 time units after negedge, well clear of posedge.
  always begin
    beat_t e;
    @(negedge clk);
    #2;
    if (!reset_n) begin
      hold_prev = 1'b0;
    end else begin
      if (framing_error) fe_cnt++;
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (hold_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_d);
        chk("stall_sop", out_startofpacket, prev_s);
        chk("stall_eop", out_endofpacket, prev_e);
        chk("stall_chan", out_channel, prev_c);
      end
      hold_prev = out_valid && !out_ready;
      prev_d = out_data;
      prev_s = out_startofpacket;
      prev_e = out_endofpacket;
      prev_c = out_channel;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat act=%0h exp=none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_data, e.d);
          chk("beat_sop", out_startofpacket, e.s);
          chk("beat_eop", out_endofpacket, e.e);
          chk("beat_chan", out_channel, e.c);
        end
      end
    end
  end

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sop", out_startofpacket, 0);
    chk("rst_eop", out_endofpacket, 0);
    chk("rst_chan", out_channel, 0);
    chk("rst_fe", framing_error, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // basic packet, plus one-cycle latency on first beat
    exp_beat(8'h11, 1, 0, 8'h00);
    exp_beat(8'h22, 0, 0, 8'h00);
    exp_beat(8'h33, 0, 1, 8'h00);
    send(8'h7A);
    send(8'h11);
    #2;
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 8'h11);
    send(8'h22);
    send(8'h7B);
    send(8'h33);
    flush();
    chk_fe("fe_basic", 0);

    // escaped control values as data
    exp_beat(8'h7A, 1, 0, 8'h00);
    exp_beat(8'h7D, 0, 1, 8'h00);
    foreach (pat[i]) ;
    send(8'h7A); send(8'h7D); send(8'h5A);
    send(8'h7B); send(8'h7D); send(8'h5D);
    flush();
    chk_fe("fe_escape", 0);

    // escaped channel value 0x7C
    exp_beat(8'h01, 1, 0, 8'h7C);
    exp_beat(8'h02, 0, 1, 8'h7C);
    send(8'h7C); send(8'h7D); send(8'h5C);
    send(8'h7A); send(8'h01); send(8'h7B); send(8'h02);
    flush();
    chk_fe("fe_chan", 0);

    // back-pressure with out_ready 1,0,0,1 pattern
    exp_beat(8'hAA, 1, 0, 8'h7C);
    exp_beat(8'hBB, 0, 0, 8'h7C);
    exp_beat(8'hCC, 0, 1, 8'h7C);
    tog = 1'b1;
    pidx = 0;
    send(8'h7A); send(8'hAA); send(8'hBB);
    send(8'h7B); send(8'hCC);
    flush();
    chk_fe("fe_stall", 0);

    // data outside packet, then repeated SOP
    send(8'h55);
    flush();
    chk_fe("fe_outside", 1);
    exp_beat(8'h01, 1, 0, 8'h7C);
    exp_beat(8'h02, 0, 1, 8'h7C);
    send(8'h7A); send(8'h7A); send(8'h01);
    send(8'h7B); send(8'h02);
    flush();
    chk_fe("fe_double_sop", 1);

    // reset mid-packet while a beat is held
    send(8'h7A);
    send(8'h10);
    out_ready = 1'b0;
    #2;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_data", out_data, 8'h10);
    chk("pre_rst_sop", out_startofpacket, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_sop", out_startofpacket, 0);
    chk("mid_rst_eop", out_endofpacket, 0);
    chk("mid_rst_chan", out_channel, 0);
    chk("mid_rst_fe", framing_error, 0);
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    reset_n = 1'b1;
    send(8'h20);
    flush();
    chk_fe("fe_after_rst", 1);

    // mid-packet channel change, unescaped 7C in CHAN, double EOP
    exp_beat(8'h41, 1, 0, 8'h00);
    exp_beat(8'h42, 0, 0, 8'h05);
    exp_beat(8'h43, 0, 1, 8'h05);
    send(8'h7A); send(8'h41); send(8'h7C); send(8'h7C);
    send(8'h05); send(8'h42); send(8'h7B); send(8'h7B);
    send(8'h43);
    flush();
    chk_fe("fe_chan_eop_err", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
